rsa_modexp_seq: RTL and testbench

Sequential Montgomery modular exponentiator with a runtime exponent. It is the private-key (decrypt/sign) counterpart of the fixed-exponent (E = 65537) public-key block in the RSA directory: `c^d mod n` recovers the plaintext that the encryption path produced. The core is a radix-2 bit-serial Montgomery multiplier driven by a left-to-right square-and-multiply FSM. It trades latency for area so that full-width private exponents are practical.

---
 rtl/rsa_modexp_seq.sv | 172 +++++++++++++++++
 tb/tb_rsa_modexp_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_seq.sv
// rsa_modexp_seq: sequential Montgomery modular exponentiator, m = c^d mod n.
// A radix-2 bit-serial Montgomery multiplier is driven by a left-to-right
// square-and-multiply FSM. Every exponent bit is processed, so latency depends
// only on LEN and popcount(d).
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   start     in   job request, sampled only while busy = 0
//   c         in   base (ciphertext), c < n
//   d         in   exponent (private key)
//   n         in   modulus, odd
//   r2_mod_n  in   R^2 mod n with R = 2^LEN
//   busy      out  job in progress
//   done      out  one-cycle pulse, m valid from this cycle on
//   m         out  result, held until the next done
module rsa_modexp_seq #(
    parameter int LEN = 256
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [LEN-1:0] c,
    input  logic [LEN-1:0] d,
    input  logic [LEN-1:0] n,
    input  logic [LEN-1:0] r2_mod_n,
    output logic           busy,
    output logic           done,
    output logic [LEN-1:0] m
);

    localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int CW = $clog2(LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        TOC,
        TOONE,
        SQR,
        MUL,
        FROM,
        FIN
    } state_t;

    state_t          state;
    logic [LEN-1:0]  cr, dr, nr, r2r;
    logic [LEN-1:0]  cbar, acc;
    logic [LEN+1:0]  t;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   ei;

    logic [LEN-1:0]  opa, opb;
    logic            abit;
    logic            last;
    logic [LEN+1:0]  s1, s2, tsh;
    logic [LEN-1:0]  tn, red;

    localparam logic [LEN-1:0] ONE = {{(LEN-1){1'b0}}, 1'b1};

    // Operand routing for the multiplication owned by the current state.
    always_comb begin
        opa = '0;
        opb = '0;
        unique case (state)
            TOC:     begin opa = cr;  opb = r2r;  end
            TOONE:   begin opa = ONE; opb = r2r;  end
            SQR:     begin opa = acc; opb = acc;  end
            MUL:     begin opa = acc; opb = cbar; end
            FROM:    begin opa = acc; opb = ONE;  end
            default: begin opa = '0;  opb = '0;   end
        endcase
    end

    // One Montgomery iteration; LEN+2 bits keep t + b + n from overflowing
    // even for out-of-contract operands.
    always_comb begin
        abit = opa[cnt[IW-1:0]];
        last = (cnt == CW'(LEN));
        s1   = t + (abit ? {2'b00, opb} : '0);
        s2   = s1 + (s1[0] ? {2'b00, nr} : '0);
        tsh  = s2 >> 1;
        tn   = t[LEN-1:0] - nr;
        red  = (t >= {2'b00, nr}) ? tn : t[LEN-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            m     <= '0;
            cr    <= '0;
            dr    <= '0;
            nr    <= '0;
            r2r   <= '0;
            cbar  <= '0;
            acc   <= '0;
            t     <= '0;
            cnt   <= '0;
            ei    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cr    <= c;
                        dr    <= d;
                        nr    <= n;
                        r2r   <= r2_mod_n;
                        busy  <= 1'b1;
                        t     <= '0;
                        cnt   <= '0;
                        state <= TOC;
                    end
                end
                // Result sits in acc for one cycle so m and done change together.
                FIN: begin
                    m     <= acc;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    if (!last) begin
                        t   <= tsh;
                        cnt <= cnt + CW'(1);
                    end else begin
                        t   <= '0;
                        cnt <= '0;
                        case (state)
                            TOC: begin
                                cbar  <= red;
                                state <= TOONE;
                            end
                            TOONE: begin
                                acc   <= red;
                                ei    <= IW'(LEN - 1);
                                state <= SQR;
                            end
                            SQR: begin
                                acc <= red;
                                if (dr[ei]) begin
                                    state <= MUL;
                                end else if (ei == '0) begin
                                    state <= FROM;
                                end else begin
                                    ei    <= ei - IW'(1);
                                    state <= SQR;
                                end
                            end
                            MUL: begin
                                acc <= red;
                                if (ei == '0) begin
                                    state <= FROM;
                                end else begin
                                    ei    <= ei - IW'(1);
                                    state <= SQR;
                                end
                            end
                            FROM: begin
                                acc   <= red;
                                state <= FIN;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_seq.sv
// Directed testbench for rsa_modexp_seq: a LEN=12 instance for the textbook
// RSA vectors and control behaviour, plus a LEN=256 instance for the wide
// cross-check vector.
module tb_rsa_modexp_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        start12;
    logic [11:0] c12, d12, n12, r12;
    logic        busy12, done12;
    logic [11:0] m12;

    logic         start2;
    logic [255:0] c2, d2, n2, r2;
    logic         busy2, done2;
    logic [255:0] m2;

    int checks   = 0;
    int failures = 0;

    rsa_modexp_seq #(.LEN(12)) dut12 (
        .clk(clk), .rst(rst), .start(start12), .c(c12), .d(d12), .n(n12),
        .r2_mod_n(r12), .busy(busy12), .done(done12), .m(m12)
    );

    rsa_modexp_seq #(.LEN(256)) dut256 (
        .clk(clk), .rst(rst), .start(start2), .c(c2), .d(d2), .n(n2),
        .r2_mod_n(r2), .busy(busy2), .done(done2), .m(m2)
    );

    // Drive a 12-bit job; the edge inside this task is edge 0 (start sampled).
    task automatic go12(input logic [11:0] cc, input logic [11:0] dd);
        c12 = cc; d12 = dd; n12 = 12'd3233; r12 = 12'd1179;
        start12 = 1'b1;
        @(posedge clk); #1;
        start12 = 1'b0;
    endtask

    // Count edges until done; also counts cycles where busy dropped early.
    task automatic wait_done12(input int limit, output int edges,
                               output int busy_low, output bit seen);
        edges = 0; busy_low = 0; seen = 1'b0;
        while (edges < limit && !seen) begin
            @(posedge clk); #1;
            edges++;
            if (done12) seen = 1'b1;
            else if (!busy12) busy_low++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start12 = 1'b0; start2 = 1'b0;
        c12 = '0; d12 = '0; n12 = '0; r12 = '0;
        c2 = '0; d2 = '0; n2 = '0; r2 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy12 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy12); end
        checks++; if (done12 !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done12); end
        checks++; if (m12 !== 12'd0)   begin failures++; $display("FAIL reset_m: got %0d expected 0", m12); end
        checks++; if (busy2 !== 1'b0 || done2 !== 1'b0 || m2 !== '0) begin
            failures++; $display("FAIL reset_wide: got busy=%b done=%b m=%h expected all 0", busy2, done2, m2);
        end
        rst = 1'b0;
    endtask

    task automatic test_textbook;
        int e, bl; bit seen;
        go12(12'd2790, 12'd2753);
        checks++; if (busy12 !== 1'b1) begin failures++; $display("FAIL tb_busy_after_start: got %b expected 1", busy12); end
        wait_done12(400, e, bl, seen);
        checks++; if (!seen)        begin failures++; $display("FAIL tb_done_timeout: got none expected done"); end
        checks++; if (e !== 261)    begin failures++; $display("FAIL tb_latency: got %0d expected 261", e); end
        checks++; if (bl !== 0)     begin failures++; $display("FAIL tb_busy_gap: got %0d low cycles expected 0", bl); end
        checks++; if (m12 !== 12'd65) begin failures++; $display("FAIL tb_m: got %0d expected 65", m12); end
        checks++; if (busy12 !== 1'b0) begin failures++; $display("FAIL tb_busy_in_done: got %b expected 0", busy12); end
        @(posedge clk); #1;
        checks++; if (done12 !== 1'b0) begin failures++; $display("FAIL tb_done_pulse: got %b expected 0", done12); end
        checks++; if (m12 !== 12'd65)  begin failures++; $display("FAIL tb_m_hold: got %0d expected 65", m12); end
    endtask

    task automatic test_edges;
        logic [11:0] vc [3] = '{12'd2790, 12'd2790, 12'd0};
        logic [11:0] vd [3] = '{12'd0, 12'd1, 12'd2753};
        logic [11:0] vm [3] = '{12'd1, 12'd2790, 12'd0};
        int          vl [3] = '{196, 209, 261};
        int e, bl; bit seen;
        for (int k = 0; k < 3; k++) begin
            go12(vc[k], vd[k]);
            wait_done12(400, e, bl, seen);
            checks++; if (e !== vl[k]) begin failures++; $display("FAIL edge_latency[%0d]: got %0d expected %0d", k, e, vl[k]); end
            checks++; if (m12 !== vm[k]) begin failures++; $display("FAIL edge_m[%0d]: got %0d expected %0d", k, m12, vm[k]); end
        end
    endtask

    task automatic test_isolation;
        int e, extra; bit seen;
        go12(12'd2790, 12'd2753);
        e = 0; seen = 1'b0;
        while (e < 400 && !seen) begin
            c12 = 12'($urandom); d12 = 12'($urandom);
            n12 = 12'($urandom); r12 = 12'($urandom);
            start12 = ~start12;
            @(posedge clk); #1;
            e++;
            if (done12) seen = 1'b1;
        end
        start12 = 1'b0;
        checks++; if (e !== 261)      begin failures++; $display("FAIL iso_latency: got %0d expected 261", e); end
        checks++; if (m12 !== 12'd65) begin failures++; $display("FAIL iso_m: got %0d expected 65", m12); end
        extra = 0;
        repeat (300) begin @(posedge clk); #1; if (done12) extra++; end
        checks++; if (extra !== 0) begin failures++; $display("FAIL iso_extra_done: got %0d expected 0", extra); end
    endtask

    task automatic test_reset_mid;
        int e, bl, cnt; bit seen;
        go12(12'd2790, 12'd2753);
        repeat (99) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy12 !== 1'b0 || done12 !== 1'b0 || m12 !== 12'd0) begin
            failures++; $display("FAIL rstmid_state: got busy=%b done=%b m=%0d expected 0 0 0", busy12, done12, m12);
        end
        cnt = 0;
        repeat (300) begin @(posedge clk); #1; if (done12) cnt++; end
        checks++; if (cnt !== 0) begin failures++; $display("FAIL rstmid_no_done: got %0d expected 0", cnt); end
        go12(12'd2790, 12'd2753);
        wait_done12(400, e, bl, seen);
        checks++; if (e !== 261 || m12 !== 12'd65) begin
            failures++; $display("FAIL rstmid_restart: got edges=%0d m=%0d expected 261 65", e, m12);
        end
    endtask

    task automatic test_rst_start;
        int cnt;
        c12 = 12'd2790; d12 = 12'd1; n12 = 12'd3233; r12 = 12'd1179;
        rst = 1'b1; start12 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start12 = 1'b0;
        checks++; if (busy12 !== 1'b0) begin failures++; $display("FAIL rststart_busy: got %b expected 0", busy12); end
        cnt = 0;
        repeat (250) begin @(posedge clk); #1; if (done12 || busy12) cnt++; end
        checks++; if (cnt !== 0) begin failures++; $display("FAIL rststart_dropped: got %0d active cycles expected 0", cnt); end
    endtask

    task automatic test_back_to_back;
        int e, bl, bad; bit seen;
        go12(12'd2790, 12'd2753);
        wait_done12(400, e, bl, seen);
        checks++; if (m12 !== 12'd65) begin failures++; $display("FAIL b2b_first_m: got %0d expected 65", m12); end
        d12 = 12'd1; start12 = 1'b1;
        @(posedge clk); #1;
        start12 = 1'b0;
        checks++; if (busy12 !== 1'b1) begin failures++; $display("FAIL b2b_accept: got busy=%b expected 1", busy12); end
        e = 0; seen = 1'b0; bad = 0;
        while (e < 400 && !seen) begin
            @(posedge clk); #1;
            e++;
            if (done12) seen = 1'b1;
            else if (m12 !== 12'd65) bad++;
        end
        checks++; if (e !== 209)        begin failures++; $display("FAIL b2b_latency: got %0d expected 209", e); end
        checks++; if (bad !== 0)        begin failures++; $display("FAIL b2b_m_hold: got %0d changed cycles expected 0", bad); end
        checks++; if (m12 !== 12'd2790) begin failures++; $display("FAIL b2b_m: got %0d expected 2790", m12); end
    endtask

    task automatic test_wide;
        int e; bit seen;
        logic [255:0] exp_m;
        exp_m = 256'h6529839e9bf0ce322932bdcc612f5f3866cf4c7abf15bff66b324e253bb35bc3;
        c2 = 256'ha1b2c3d4e5f67890123456789012345678901234567890123456789012345678;
        n2 = 256'hfffffffffffffffffffffffffffffffffffffffffffffffffffffffefffffc2f;
        r2 = 256'h1000007a2000e90a1;
        d2 = 256'd65537;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        e = 0; seen = 1'b0;
        while (e < 70000 && !seen) begin
            @(posedge clk); #1;
            e++;
            if (done2) seen = 1'b1;
        end
        checks++; if (e !== 67078) begin failures++; $display("FAIL wide_latency: got %0d expected 67078", e); end
        checks++; if (m2 !== exp_m) begin failures++; $display("FAIL wide_m: got %h expected %h", m2, exp_m); end
    endtask

    initial begin
        test_reset;
        test_textbook;
        test_edges;
        test_isolation;
        test_reset_mid;
        test_rst_start;
        test_back_to_back;
        test_wide;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
